vx_muldiv_share_sched: RTL and testbench
========================================

Name: vx_muldiv_share_sched

Overview:
- Scheduler sharing one iterative (non-pipelined) divider among NUM_REQS ALU blocks.
- Each ALU block presents a div request (operands + tag). The scheduler grants round-robin, launches the divider, tracks completion and routes the result back to the owning block's response channel.
- Sits between per-block muldiv dispatch and a single shared divider core; the multiplier path is not involved.

Parameters:
- NUM_REQS, 4, number of requesting ALU blocks (1..16)
- DATAW, 2*XLEN+3, request payload width (operands + op variant)
- RSPW, XLEN, result width
- TAGW, UUID_WIDTH+NW_WIDTH+8, opaque tag echoed with the result
- TIMEOUT, 255, max cycles in WAIT before err_timeout pulses; 0 disables

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQS  per-block request valid
- req_data  in  NUM_REQS*DATAW  per-block payload
- req_tag  in  NUM_REQS*TAGW  per-block tag
- req_ready  out  NUM_REQS  per-block accept
- div_valid  out  1  launch to divider
- div_data  out  DATAW  divider payload
- div_ready  in  1  divider accepts launch
- div_done  in  1  divider result valid (one-cycle pulse)
- div_result  in  RSPW  divider result
- rsp_valid  out  NUM_REQS  per-block response valid
- rsp_data  out  RSPW  response result (shared bus; qualified by rsp_valid)
- rsp_tag  out  TAGW  echoed tag
- rsp_ready  in  NUM_REQS  per-block response accept
- busy  out  1  scheduler not IDLE
- err_timeout  out  1  one-cycle pulse on WAIT timeout

Behaviour:
- Reset (reset=0, async): state=IDLE, rr_ptr=0, grant/tag/result regs=0; all outputs 0 (req_ready, div_valid, rsp_valid, busy, err_timeout).
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Round-robin arbitration over req_valid, starting at rr_ptr.
  - If any request is valid, assert req_ready only for the winner (same cycle, combinational).
  - On fire, latch data, tag and grant index; set rr_ptr = winner+1 mod NUM_REQS; go to ISSUE.
  - No request: stay in IDLE and leave rr_ptr unchanged.
- ISSUE:
  - div_valid=1 with the latched data.
  - On div_ready go to WAIT and clear the timeout counter.
  - div_valid holds with stable data until accepted.
- WAIT:
  - Count cycles.
  - On div_done, latch div_result and go to RESP.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT without div_done: pulse err_timeout, latch result=0, go to RESP (lane is released; the error is reported, not hung).
  - If div_done arrives in the same cycle the counter hits TIMEOUT, div_done wins and err_timeout does not pulse.
- RESP:
  - rsp_valid[grant]=1, all other rsp_valid bits 0; rsp_data/rsp_tag come from the latched regs.
  - Hold until rsp_ready[grant], then go to IDLE.
  - No new request is accepted in the RESP cycle (no bypass).
- Latency: accept cycle -> div_valid next cycle. If the divider accepts immediately and completes after D cycles, rsp_valid rises 1 cycle after div_done. Minimum overhead is 3 cycles beyond D.
- At most one operation is outstanding. req_ready is 0 in every state except IDLE.
- div_done outside WAIT is ignored (and flagged by an assertion).
- Reset mid-operation: abandon the op, return to IDLE, drop the outstanding response. The divider is reset from the same net.
- NUM_REQS=1: the arbiter degenerates to a pass-through and rr_ptr is constant 0.
- Assertions:
  - one-hot req_ready;
  - one-hot rsp_valid;
  - div_data stable while div_valid && !div_ready;
  - rsp_* stable while rsp_valid && !rsp_ready.

Decomposition:
- Shared package holds:
  - state enum (IDLE, ISSUE, WAIT, RESP; 2 bits);
  - the REQ_SEL_W = CLOG2(NUM_REQS) helper;
  - the timeout counter width TOW = CLOG2(TIMEOUT+1).
- One sub-module: vx_rr_pick, a combinational round-robin priority picker (inputs: valid vector, rr_ptr; outputs: one-hot grant, grant index, any-valid).
- Everything else is the FSM plus latch registers in the top.

Test Plan:
- Single request: block 2 sends tag=0x15, divider accepts at once, div_done after 10 cycles with result 0x7 -> rsp_valid=0100, rsp_tag=0x15, rsp_data=0x7, one cycle after div_done; req_ready[2] was high only in the accept cycle.
- Fairness: all 4 blocks continuously valid, rr_ptr=0 -> grants in order 0,1,2,3,0 across 5 ops; no block is granted twice before every other valid block has been granted.
- Back-pressure: div_ready held low 5 cycles in ISSUE, then rsp_ready[1] held low 4 cycles in RESP -> div_data and rsp_data/tag stable throughout; no req_ready asserted during either hold.
- Timeout: TIMEOUT=8, div_done never arrives -> err_timeout pulses exactly once, 8 cycles after entering WAIT; rsp_valid[grant]=1 with rsp_data=0; FSM returns to IDLE after rsp_ready.
- Tie: div_done in the same cycle the counter reaches TIMEOUT -> no err_timeout pulse, real result returned.
- Async reset mid-WAIT: drop reset to 0 asynchronously -> all outputs 0 immediately; after release, busy=0 and rr_ptr=0; a stray div_done arriving after release is ignored.

Source files
------------

// File: rtl/vx_muldiv_share_sched_pkg.sv
// Shared types and width helpers for the shared-divider scheduler.
// Imported by the scheduler top and its round-robin picker.
package vx_muldiv_share_sched_pkg;

  localparam int XLEN       = 32;
  localparam int UUID_WIDTH = 44;
  localparam int NW_WIDTH   = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } sched_state_e;

  function automatic int req_sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int tout_w(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/vx_rr_pick.sv
// Combinational round-robin picker: first valid requester
// at or after rr_ptr, wrapping around.
module vx_rr_pick
  import vx_muldiv_share_sched_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int SW       = req_sel_w(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] valid,
  input  logic [SW-1:0]       rr_ptr,
  output logic [NUM_REQS-1:0] grant,
  output logic [SW-1:0]       grant_idx,
  output logic                any_valid
);

  int j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    j         = 0;
    for (int i = 0; i < NUM_REQS; i++) begin
      j = (int'(rr_ptr) + i) % NUM_REQS;
      if (!any_valid && valid[j]) begin
        any_valid = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = SW'(j);
      end
    end
  end

endmodule

// File: rtl/vx_muldiv_share_sched.sv
// Shares one iterative divider among NUM_REQS ALU blocks:
// round-robin grant, single outstanding op, routed response.
module vx_muldiv_share_sched
  import vx_muldiv_share_sched_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 2 * XLEN + 3,
  parameter int RSPW     = XLEN,
  parameter int TAGW     = UUID_WIDTH + NW_WIDTH + 8,
  parameter int TIMEOUT  = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQS-1:0]      req_valid,
  input  logic [NUM_REQS*DATAW-1:0] req_data,
  input  logic [NUM_REQS*TAGW-1:0] req_tag,
  output logic [NUM_REQS-1:0]      req_ready,
  output logic                     div_valid,
  output logic [DATAW-1:0]         div_data,
  input  logic                     div_ready,
  input  logic                     div_done,
  input  logic [RSPW-1:0]          div_result,
  output logic [NUM_REQS-1:0]      rsp_valid,
  output logic [RSPW-1:0]          rsp_data,
  output logic [TAGW-1:0]          rsp_tag,
  input  logic [NUM_REQS-1:0]      rsp_ready,
  output logic                     busy,
  output logic                     err_timeout
);

  localparam int SW  = req_sel_w(NUM_REQS);
  localparam int TOW = tout_w(TIMEOUT);
  localparam logic [TOW-1:0] TO_LIM = TOW'(TIMEOUT);

  sched_state_e        state;
  logic [SW-1:0]       rr_ptr;
  logic [NUM_REQS-1:0] gnt_q;
  logic [DATAW-1:0]    data_q;
  logic [TAGW-1:0]     tag_q;
  logic [RSPW-1:0]     res_q;
  logic [TOW-1:0]      cnt;
  logic [TOW-1:0]      cnt_nxt;

  logic [NUM_REQS-1:0] pick_gnt;
  logic [SW-1:0]       pick_idx;
  logic                pick_any;

  vx_rr_pick #(
    .NUM_REQS (NUM_REQS),
    .SW       (SW)
  ) u_pick (
    .valid     (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (pick_gnt),
    .grant_idx (pick_idx),
    .any_valid (pick_any)
  );

  // Gated by reset so req_ready drops the moment reset asserts.
  assign req_ready = (reset && state == S_IDLE) ? pick_gnt : '0;
  assign cnt_nxt   = cnt + 1'b1;
  assign div_data  = data_q;
  assign rsp_data  = res_q;
  assign rsp_tag   = tag_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      gnt_q       <= '0;
      data_q      <= '0;
      tag_q       <= '0;
      res_q       <= '0;
      cnt         <= '0;
      div_valid   <= 1'b0;
      rsp_valid   <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (pick_any) begin
            data_q    <= req_data[int'(pick_idx)*DATAW +: DATAW];
            tag_q     <= req_tag[int'(pick_idx)*TAGW +: TAGW];
            gnt_q     <= pick_gnt;
            rr_ptr    <= (int'(pick_idx) == NUM_REQS - 1) ?
                         '0 : pick_idx + 1'b1;
            div_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (div_ready) begin
            div_valid <= 1'b0;
            cnt       <= '0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A completion on the last allowed cycle beats the timeout.
          if (div_done) begin
            res_q     <= div_result;
            rsp_valid <= gnt_q;
            state     <= S_RESP;
          end else if (TIMEOUT != 0 && cnt_nxt == TO_LIM) begin
            res_q       <= '0;
            rsp_valid   <= gnt_q;
            err_timeout <= 1'b1;
            state       <= S_RESP;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        S_RESP: begin
          if (|(rsp_ready & gnt_q)) begin
            rsp_valid <= '0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  a_req_oh: assert property (@(posedge clk) disable iff (!reset)
    $onehot0(req_ready));

  a_rsp_oh: assert property (@(posedge clk) disable iff (!reset)
    $onehot0(rsp_valid));

  a_div_hold: assert property (@(posedge clk) disable iff (!reset)
    div_valid && !div_ready |=> div_valid && $stable(div_data));

  a_rsp_hold: assert property (@(posedge clk) disable iff (!reset)
    (|rsp_valid) && !(|(rsp_valid & rsp_ready)) |=>
      $stable(rsp_valid) && $stable(rsp_data) && $stable(rsp_tag));

  a_stray_done: assert property (@(posedge clk) disable iff (!reset)
    div_done |-> state == S_WAIT)
    else $warning("div_done outside WAIT ignored");

endmodule

// File: tb/tb_vx_muldiv_share_sched.sv
// Directed bench for the shared-divider scheduler: arbitration,
// back-pressure, timeout, tie and async reset.
module tb_vx_muldiv_share_sched;

  localparam int NR = 4;
  localparam int DW = 67;
  localparam int RW = 32;
  localparam int TW = 54;
  localparam int TO = 12;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR*TW-1:0] req_tag = '0;
  logic [NR-1:0]    req_ready;
  logic             div_valid;
  logic [DW-1:0]    div_data;
  logic             div_ready = 1'b0;
  logic             div_done = 1'b0;
  logic [RW-1:0]    div_result = '0;
  logic [NR-1:0]    rsp_valid;
  logic [RW-1:0]    rsp_data;
  logic [TW-1:0]    rsp_tag;
  logic [NR-1:0]    rsp_ready = '0;
  logic             busy;
  logic             err_timeout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vx_muldiv_share_sched #(
    .NUM_REQS (NR),
    .DATAW    (DW),
    .RSPW     (RW),
    .TAGW     (TW),
    .TIMEOUT  (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_tag     (req_tag),
    .req_ready   (req_ready),
    .div_valid   (div_valid),
    .div_data    (div_data),
    .div_ready   (div_ready),
    .div_done    (div_done),
    .div_result  (div_result),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_tag     (rsp_tag),
    .rsp_ready   (rsp_ready),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full op; done asserted in WAIT cycle d-1 (d >= 1).
  task automatic do_op(input logic [3:0] vmask,
                       input logic [3:0] exp,
                       input int d,
                       input logic [31:0] res);
    int b = 0;
    for (int i = 0; i < NR; i++) if (exp[i]) b = i;
    req_valid = vmask;
    div_ready = 1'b1;
    #1;
    chk("req_ready_idle", req_ready, exp);
    step();
    chk("div_valid", div_valid, 1);
    chk("div_data", div_data, 256 + b);
    chk("req_ready_issue", req_ready, 0);
    step();
    div_ready = 1'b0;
    for (int w = 0; w < d; w++) begin
      if (w > 0) step();
      div_done   = (w == d - 1);
      div_result = res;
    end
    step();
    div_done = 1'b0;
    chk("rsp_valid", rsp_valid, exp);
    chk("rsp_data", rsp_data, res);
    chk("rsp_tag", rsp_tag, 8'h13 + b);
    chk("err_resp", err_timeout, 0);
    chk("req_ready_resp", req_ready, 0);
    rsp_ready = exp;
    step();
    rsp_ready = '0;
    chk("busy_done", busy, 0);
    chk("rsp_valid_done", rsp_valid, 0);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      req_data[i*DW +: DW] = DW'(256 + i);
      req_tag[i*TW +: TW]  = TW'(8'h13 + i);
    end

    // reset state, with requests pending
    req_valid = 4'hF;
    #2 reset = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_div_valid", div_valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_err", err_timeout, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset     = 1'b1;
    req_valid = '0;
    step();

    // fairness: all valid, grants 0,1,2,3,0
    do_op(4'hF, 4'h1, 1, 32'h11);
    do_op(4'hF, 4'h2, 1, 32'h22);
    do_op(4'hF, 4'h4, 1, 32'h33);
    do_op(4'hF, 4'h8, 1, 32'h44);
    do_op(4'hF, 4'h1, 1, 32'h55);
    req_valid = '0;

    // single request from block 2, done after 10 cycles
    do_op(4'h4, 4'h4, 10, 32'h7);
    req_valid = '0;

    // back-pressure on block 1
    req_valid = 4'h2;
    div_ready = 1'b0;
    #1;
    chk("bp_req_ready", req_ready, 4'h2);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_div_valid", div_valid, 1);
      chk("bp_div_data", div_data, 257);
      chk("bp_req_ready_issue", req_ready, 0);
      step();
    end
    div_ready = 1'b1;
    #1;
    chk("bp_div_data_acc", div_data, 257);
    step();
    div_ready  = 1'b0;
    div_done   = 1'b1;
    div_result = 32'h5A5A;
    step();
    div_done  = 1'b0;
    rsp_ready = 4'hD;
    for (int i = 0; i < 4; i++) begin
      chk("bp_rsp_valid", rsp_valid, 4'h2);
      chk("bp_rsp_data", rsp_data, 32'h5A5A);
      chk("bp_rsp_tag", rsp_tag, 8'h14);
      chk("bp_req_ready_resp", req_ready, 0);
      step();
    end
    rsp_ready = 4'h2;
    step();
    rsp_ready = '0;
    req_valid = '0;
    chk("bp_busy", busy, 0);

    // timeout on block 0
    req_valid = 4'h1;
    div_ready = 1'b1;
    #1;
    chk("to_req_ready", req_ready, 4'h1);
    step();
    step();
    div_ready = 1'b0;
    req_valid = '0;
    for (int w = 0; w < TO; w++) begin
      chk("to_err_early", err_timeout, 0);
      step();
    end
    chk("to_err_pulse", err_timeout, 1);
    chk("to_rsp_valid", rsp_valid, 4'h1);
    chk("to_rsp_data", rsp_data, 0);
    step();
    chk("to_err_once", err_timeout, 0);
    chk("to_rsp_hold", rsp_valid, 4'h1);
    rsp_ready = 4'h1;
    step();
    rsp_ready = '0;
    chk("to_busy", busy, 0);

    // tie: done on the cycle the counter hits TIMEOUT
    do_op(4'h8, 4'h8, TO, 32'hABC);
    req_valid = '0;

    // async reset mid-WAIT
    req_valid = 4'h2;
    div_ready = 1'b1;
    #1;
    chk("ar_req_ready", req_ready, 4'h2);
    step();
    step();
    div_ready = 1'b0;
    step();
    step();
    #3 reset = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_div_valid", div_valid, 0);
    chk("ar_rsp_valid", rsp_valid, 0);
    chk("ar_req_ready", req_ready, 0);
    chk("ar_div_data", div_data, 0);
    chk("ar_rsp_tag", rsp_tag, 0);
    @(negedge clk);
    reset     = 1'b1;
    req_valid = '0;
    step();
    div_done   = 1'b1;
    div_result = 32'hDEAD;
    step();
    div_done = 1'b0;
    chk("ar_stray_busy", busy, 0);
    chk("ar_stray_rsp", rsp_valid, 0);
    req_valid = 4'hF;
    #1;
    chk("ar_rr_ptr", req_ready, 4'h1);
    req_valid = '0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
